periph_read_mux: RTL and testbench
==================================

PERIPH_READ_MUX -- requirements
Module: periph_read_mux

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  NUM_SLV, 4, number of peripheral read ports (2..16).
  DATA_W, 32, read data width.
  TIMEOUT, 16, maximum WAIT cycles before the access is aborted (2..255).
  DEFAULT_DATA, 32'h0, data returned on error or when idle.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clk  input  1  single clock; all flops on the rising edge.
  n_rst  input  1  asynchronous, active-low reset.
  req_valid  input  1  CPU issues a bus access this cycle.
  req_we  input  1  access is a write; writes get no read response.
  cs_n  input  NUM_SLV  active-low chip selects from the address decoder.
  slv_rdata  input  NUM_SLV*DATA_W  concatenated slave read data; slave i at bits [i*DATA_W +: DATA_W].
  slv_ready  input  NUM_SLV  slave i read data valid; fixed-latency slaves tie it high.
  err_clr  input  1  clears err_sticky.
  read_data  output  DATA_W  muxed read data.
  read_valid  output  1  read_data valid this cycle.
  busy  output  1  CPU must stall; new requests are ignored.
  err  output  1  pulses with read_valid on an errored response.
  err_code  output  2  00 ok, 01 no select, 10 multiple select, 11 timeout.
  err_sticky  output  1  set by any error; held until err_clr.

Function
REQ-003 The FSM SHALL have the states IDLE, WAIT and ERR_RSP.
REQ-004 In IDLE, req_valid=1 with req_we=0 SHALL capture the select into sel_q, using the lowest index whose cs_n bit is low, and SHALL clear tcnt.
REQ-005 A read request in IDLE with exactly one cs_n bit low SHALL move the FSM to WAIT.
REQ-006 A read request in IDLE with zero or more than one cs_n bit low SHALL move the FSM to ERR_RSP, latching err_code 01 or 10 respectively.
REQ-007 A write request (req_we=1), or req_valid=0, SHALL leave the FSM in IDLE with no response.
REQ-008 In WAIT with slv_ready[sel_q]=1, the block SHALL drive read_valid=1 and read_data=slice sel_q of slv_rdata combinationally in that cycle, with err=0 and err_code=00.
REQ-009 In WAIT with slv_ready[sel_q]=1, the next state SHALL be IDLE.
REQ-010 In WAIT with slv_ready[sel_q]=0, tcnt SHALL increment by 1 each cycle; when tcnt reaches TIMEOUT-1, the next state SHALL be ERR_RSP with err_code 11.
REQ-011 In ERR_RSP, the block SHALL drive read_valid=1, err=1, read_data=DEFAULT_DATA and the latched err_code for exactly one cycle, then return to IDLE.
REQ-012 With slv_ready tied high, read latency SHALL be exactly 1 cycle (request at cycle N, read_valid at cycle N+1), matching the previous-generation registered-select timing.
REQ-013 busy SHALL be 1 in WAIT when slv_ready[sel_q]=0, and 0 in all other cases.
REQ-014 req_valid while busy=1 SHALL be ignored.
REQ-015 req_valid in the same cycle as a WAIT completion or ERR_RSP SHALL be ignored; the CPU re-issues it.
REQ-016 Whenever read_valid=0, read_data SHALL equal DEFAULT_DATA and err_code SHALL be 00.
REQ-017 err_sticky SHALL set on any cycle with err=1.
REQ-018 err_clr SHALL clear err_sticky; if err_clr and err are both 1 in the same cycle, err_sticky SHALL remain 1 (set wins).
REQ-019 tcnt SHALL be $clog2(TIMEOUT) bits wide and SHALL never wrap, because it is reset on every entry to WAIT.
REQ-020 A change of cs_n during WAIT SHALL NOT affect the access; only sel_q is used.

Reset
REQ-021 Asserting n_rst low SHALL immediately force state=IDLE, sel_q=0, tcnt=0, latched err_code=00 and err_sticky=0.
REQ-022 During reset, outputs SHALL be read_valid=0, err=0, busy=0 and read_data=DEFAULT_DATA.
REQ-023 Reset asserted mid-WAIT SHALL abort the access with no response generated after reset release.

Structure
REQ-024 The package periph_bus_pkg SHALL hold the state encoding and the err_code constants ERR_NONE, ERR_NOSEL, ERR_MULTISEL and ERR_TIMEOUT.
REQ-025 One sub-module, periph_sel_decode (combinational; cs_n to index plus a select-count class of none/one/multi), SHALL be instantiated.
REQ-026 No other hierarchy SHALL be used.

Verification
REQ-027 cs_n=4'b1101, read request, slv_ready=4'hF, slave1 data 32'hDEADBEEF -> next cycle read_valid=1, read_data=32'hDEADBEEF, err=0.
REQ-028 cs_n=4'b1011, slv_ready[2] low for 3 cycles then high with data 32'h12345678 -> busy=1 for 3 cycles, then read_valid=1, read_data=32'h12345678.
REQ-029 cs_n=4'b1111, read request -> next cycle read_valid=1, err=1, err_code=01, read_data=32'h0, err_sticky=1 until err_clr.
REQ-030 cs_n=4'b0110, read request -> ERR_RSP with err_code=10.
REQ-031 TIMEOUT=16, slv_ready[0] held low -> busy=1 for 15 cycles, then one cycle with err_code=11, read_data=32'h0, then IDLE.
REQ-032 n_rst pulsed low during WAIT, then slv_ready high after release -> no read_valid; the next request completes normally.

Source files
------------

// File: rtl/periph_bus_pkg.sv
// Shared types and constants for the peripheral read-data multiplexer.
package periph_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ERR_RSP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE  = 2'd0,
        SEL_ONE   = 2'd1,
        SEL_MULTI = 2'd2
    } sel_class_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_NOSEL    = 2'b01;
    localparam logic [1:0] ERR_MULTISEL = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

endpackage

// File: rtl/periph_sel_decode.sv
// Chip-select decoder: lowest active-low select index plus none/one/multi class.
import periph_bus_pkg::*;

module periph_sel_decode #(
    parameter int NUM_SLV = 4,
    parameter int IDX_W   = $clog2(NUM_SLV)
) (
    input  logic [NUM_SLV-1:0] i_cs_n,
    output logic [IDX_W-1:0]   o_idx,
    output sel_class_t         o_sel_class
);

    logic w_found;
    logic w_multi;

    always_comb begin
        o_idx   = '0;
        w_found = 1'b0;
        w_multi = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (!i_cs_n[i]) begin
                if (w_found) begin
                    w_multi = 1'b1;
                end else begin
                    o_idx   = i[IDX_W-1:0];
                    w_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        if (!w_found) begin
            o_sel_class = SEL_NONE;
        end else if (w_multi) begin
            o_sel_class = SEL_MULTI;
        end else begin
            o_sel_class = SEL_ONE;
        end
    end

endmodule

// File: rtl/periph_read_mux.sv
// CPU read-data multiplexer over NUM_SLV peripherals with wait-state support,
// select-error detection, access timeout and a sticky error flag.
import periph_bus_pkg::*;

module periph_read_mux #(
    parameter int                NUM_SLV      = 4,
    parameter int                DATA_W       = 32,
    parameter int                TIMEOUT      = 16,
    parameter logic [DATA_W-1:0] DEFAULT_DATA = 32'h0
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        req_valid,
    input  logic                        req_we,
    input  logic [NUM_SLV-1:0]          cs_n,
    input  logic [NUM_SLV*DATA_W-1:0]   slv_rdata,
    input  logic [NUM_SLV-1:0]          slv_ready,
    input  logic                        err_clr,
    output logic [DATA_W-1:0]           read_data,
    output logic                        read_valid,
    output logic                        busy,
    output logic                        err,
    output logic [1:0]                  err_code,
    output logic                        err_sticky
);

    localparam int IDX_W  = $clog2(NUM_SLV);
    localparam int TCNT_W = $clog2(TIMEOUT);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    state_t              r_state;
    logic [IDX_W-1:0]    r_sel_q;
    logic [TCNT_W-1:0]   r_tcnt;
    logic [1:0]          r_err_code;
    logic                r_err_sticky;

    logic [IDX_W-1:0]    w_idx;
    sel_class_t          w_sel_class;
    logic [DATA_W-1:0]   w_slices [NUM_SLV];
    logic [DATA_W-1:0]   w_rdata_sel;
    logic                w_rdy_sel;
    logic [TCNT_W-1:0]   w_tcnt_inc;
    logic                w_rd_req;
    logic                w_done;
    logic                w_err;

    periph_sel_decode #(
        .NUM_SLV (NUM_SLV),
        .IDX_W   (IDX_W)
    ) u_sel_decode (
        .i_cs_n      (cs_n),
        .o_idx       (w_idx),
        .o_sel_class (w_sel_class)
    );

    for (genvar g = 0; g < NUM_SLV; g++) begin : g_slice
        assign w_slices[g] = slv_rdata[g*DATA_W +: DATA_W];
    end

    // Only the captured select steers the data path; live cs_n is ignored in WAIT.
    assign w_rdata_sel = w_slices[r_sel_q];
    assign w_rdy_sel   = slv_ready[r_sel_q];
    assign w_tcnt_inc  = r_tcnt + 1'b1;
    assign w_rd_req    = req_valid && !req_we;
    assign w_done      = (r_state == ST_WAIT) && w_rdy_sel;
    assign w_err       = (r_state == ST_ERR_RSP);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= ST_IDLE;
            r_sel_q    <= '0;
            r_tcnt     <= '0;
            r_err_code <= ERR_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rd_req) begin
                        r_sel_q <= w_idx;
                        r_tcnt  <= '0;
                        case (w_sel_class)
                            SEL_ONE: begin
                                r_state    <= ST_WAIT;
                                r_err_code <= ERR_NONE;
                            end
                            SEL_NONE: begin
                                r_state    <= ST_ERR_RSP;
                                r_err_code <= ERR_NOSEL;
                            end
                            default: begin
                                r_state    <= ST_ERR_RSP;
                                r_err_code <= ERR_MULTISEL;
                            end
                        endcase
                    end
                end
                ST_WAIT: begin
                    if (w_rdy_sel) begin
                        r_state <= ST_IDLE;
                    end else begin
                        // Abort once the incremented count hits TIMEOUT-1.
                        r_tcnt <= w_tcnt_inc;
                        if (w_tcnt_inc == TCNT_LAST) begin
                            r_state    <= ST_ERR_RSP;
                            r_err_code <= ERR_TIMEOUT;
                        end
                    end
                end
                ST_ERR_RSP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Set wins over clear when both happen in the same cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_err_sticky <= 1'b0;
        end else if (w_err) begin
            r_err_sticky <= 1'b1;
        end else if (err_clr) begin
            r_err_sticky <= 1'b0;
        end
    end

    always_comb begin
        read_data  = DEFAULT_DATA;
        read_valid = 1'b0;
        err        = 1'b0;
        err_code   = ERR_NONE;
        busy       = 1'b0;
        if (w_done) begin
            read_data  = w_rdata_sel;
            read_valid = 1'b1;
        end else if (w_err) begin
            read_valid = 1'b1;
            err        = 1'b1;
            err_code   = r_err_code;
        end else if (r_state == ST_WAIT) begin
            busy = 1'b1;
        end
    end

    assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_periph_read_mux.sv
// Directed bench for periph_read_mux with default parameters.
module tb_periph_read_mux;

    logic         clk;
    logic         n_rst;
    logic         req_valid;
    logic         req_we;
    logic [3:0]   cs_n;
    logic [127:0] slv_rdata;
    logic [3:0]   slv_ready;
    logic         err_clr;
    logic [31:0]  read_data;
    logic         read_valid;
    logic         busy;
    logic         err;
    logic [1:0]   err_code;
    logic         err_sticky;

    int checks;
    int failures;

    periph_read_mux dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .cs_n       (cs_n),
        .slv_rdata  (slv_rdata),
        .slv_ready  (slv_ready),
        .err_clr    (err_clr),
        .read_data  (read_data),
        .read_valid (read_valid),
        .busy       (busy),
        .err        (err),
        .err_code   (err_code),
        .err_sticky (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; req_valid = 1'b1; req_we = 1'b0; cs_n = 4'b1110;
        slv_ready = 4'hF; err_clr = 1'b0;
        next_cycle(); next_cycle();
        #1;
        checks++; if (read_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", read_valid); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL rst_err: got %b want 0", err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (read_data !== 32'h0) begin failures++; $display("FAIL rst_data: got %h want 00000000", read_data); end
        checks++; if (err_code !== 2'b00) begin failures++; $display("FAIL rst_code: got %b want 00", err_code); end
        checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL rst_sticky: got %b want 0", err_sticky); end
        req_valid = 1'b0;
        next_cycle();
        n_rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_single_cycle();
        req_valid = 1'b1; req_we = 1'b0; cs_n = 4'b1101; slv_ready = 4'hF;
        next_cycle();
        req_valid = 1'b0;
        #1;
        checks++; if (read_valid !== 1'b1) begin failures++; $display("FAIL s1_valid: got %b want 1", read_valid); end
        checks++; if (read_data !== 32'hDEADBEEF) begin failures++; $display("FAIL s1_data: got %h want deadbeef", read_data); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL s1_err: got %b want 0", err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL s1_busy: got %b want 0", busy); end
        next_cycle();
        #1;
        checks++; if (read_valid !== 1'b0) begin failures++; $display("FAIL s1_idle_valid: got %b want 0", read_valid); end
        checks++; if (read_data !== 32'h0) begin failures++; $display("FAIL s1_idle_data: got %h want 00000000", read_data); end
        req_valid = 1'b1; cs_n = 4'b0111;
        next_cycle();
        req_valid = 1'b0;
        #1;
        checks++; if (read_data !== 32'hCAFEF00D) begin failures++; $display("FAIL s3_data: got %h want cafef00d", read_data); end
        next_cycle();
    endtask

    task automatic test_write_ignored();
        req_valid = 1'b1; req_we = 1'b1; cs_n = 4'b1101; slv_ready = 4'hF;
        next_cycle();
        req_valid = 1'b0; req_we = 1'b0;
        #1;
        checks++; if (read_valid !== 1'b0) begin failures++; $display("FAIL wr_valid: got %b want 0", read_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wr_busy: got %b want 0", busy); end
        next_cycle();
    endtask

    task automatic test_wait_states();
        req_valid = 1'b1; req_we = 1'b0; cs_n = 4'b1011; slv_ready = 4'b1011;
        next_cycle();
        req_valid = 1'b0;
        cs_n = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ws_busy%0d: got %b want 1", k, busy); end
            checks++; if (read_valid !== 1'b0) begin failures++; $display("FAIL ws_valid%0d: got %b want 0", k, read_valid); end
            checks++; if (read_data !== 32'h0) begin failures++; $display("FAIL ws_data%0d: got %h want 00000000", k, read_data); end
            next_cycle();
        end
        slv_ready = 4'hF;
        req_valid = 1'b1;
        #1;
        checks++; if (read_valid !== 1'b1) begin failures++; $display("FAIL ws_done_valid: got %b want 1", read_valid); end
        checks++; if (read_data !== 32'h12345678) begin failures++; $display("FAIL ws_done_data: got %h want 12345678", read_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ws_done_busy: got %b want 0", busy); end
        next_cycle();
        req_valid = 1'b0;
        #1;
        checks++; if (read_valid !== 1'b0) begin failures++; $display("FAIL ws_ignored_req: got %b want 0", read_valid); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_v;
        exp_v = 4'b1010;
        req_valid = 1'b1; req_we = 1'b0; cs_n = 4'b1110; slv_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (read_valid !== exp_v[k]) begin failures++; $display("FAIL b2b_valid%0d: got %b want %b", k, read_valid, exp_v[k]); end
            next_cycle();
        end
        req_valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_nosel();
        req_valid = 1'b1; req_we = 1'b0; cs_n = 4'b1111; slv_ready = 4'hF;
        next_cycle();
        req_valid = 1'b0;
        #1;
        checks++; if (read_valid !== 1'b1) begin failures++; $display("FAIL ns_valid: got %b want 1", read_valid); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL ns_err: got %b want 1", err); end
        checks++; if (err_code !== 2'b01) begin failures++; $display("FAIL ns_code: got %b want 01", err_code); end
        checks++; if (read_data !== 32'h0) begin failures++; $display("FAIL ns_data: got %h want 00000000", read_data); end
        checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL ns_sticky_pre: got %b want 0", err_sticky); end
        next_cycle();
        #1;
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL ns_err_after: got %b want 0", err); end
        checks++; if (err_code !== 2'b00) begin failures++; $display("FAIL ns_code_after: got %b want 00", err_code); end
        checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL ns_sticky_set: got %b want 1", err_sticky); end
        next_cycle(); next_cycle();
        #1;
        checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL ns_sticky_hold: got %b want 1", err_sticky); end
        err_clr = 1'b1;
        next_cycle();
        err_clr = 1'b0;
        #1;
        checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL ns_sticky_clr: got %b want 0", err_sticky); end
        next_cycle();
    endtask

    task automatic test_multisel();
        req_valid = 1'b1; req_we = 1'b0; cs_n = 4'b0110; slv_ready = 4'hF;
        next_cycle();
        req_valid = 1'b0;
        err_clr = 1'b1;
        #1;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL ms_err: got %b want 1", err); end
        checks++; if (err_code !== 2'b10) begin failures++; $display("FAIL ms_code: got %b want 10", err_code); end
        checks++; if (read_data !== 32'h0) begin failures++; $display("FAIL ms_data: got %h want 00000000", read_data); end
        next_cycle();
        err_clr = 1'b0;
        #1;
        checks++; if (err_sticky !== 1'b1) begin failures++; $display("FAIL ms_set_wins: got %b want 1", err_sticky); end
        err_clr = 1'b1;
        next_cycle();
        err_clr = 1'b0;
        next_cycle();
    endtask

    task automatic test_timeout();
        req_valid = 1'b1; req_we = 1'b0; cs_n = 4'b1110; slv_ready = 4'b1110;
        next_cycle();
        req_valid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            #1;
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL to_busy%0d: got %b want 1", k, busy); end
            next_cycle();
        end
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL to_busy_end: got %b want 0", busy); end
        checks++; if (read_valid !== 1'b1) begin failures++; $display("FAIL to_valid: got %b want 1", read_valid); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_err: got %b want 1", err); end
        checks++; if (err_code !== 2'b11) begin failures++; $display("FAIL to_code: got %b want 11", err_code); end
        checks++; if (read_data !== 32'h0) begin failures++; $display("FAIL to_data: got %h want 00000000", read_data); end
        next_cycle();
        slv_ready = 4'hF;
        #1;
        checks++; if (read_valid !== 1'b0) begin failures++; $display("FAIL to_idle_valid: got %b want 0", read_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL to_idle_busy: got %b want 0", busy); end
        next_cycle();
    endtask

    task automatic test_reset_mid_wait();
        req_valid = 1'b1; req_we = 1'b0; cs_n = 4'b1101; slv_ready = 4'b1101;
        next_cycle();
        req_valid = 1'b0;
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rw_busy: got %b want 1", busy); end
        n_rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rw_busy_rst: got %b want 0", busy); end
        checks++; if (err_sticky !== 1'b0) begin failures++; $display("FAIL rw_sticky_rst: got %b want 0", err_sticky); end
        next_cycle();
        n_rst = 1'b1;
        slv_ready = 4'hF;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (read_valid !== 1'b0) begin failures++; $display("FAIL rw_no_rsp%0d: got %b want 0", k, read_valid); end
            next_cycle();
        end
        req_valid = 1'b1;
        next_cycle();
        req_valid = 1'b0;
        #1;
        checks++; if (read_valid !== 1'b1) begin failures++; $display("FAIL rw_after_valid: got %b want 1", read_valid); end
        checks++; if (read_data !== 32'hDEADBEEF) begin failures++; $display("FAIL rw_after_data: got %h want deadbeef", read_data); end
        next_cycle();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        slv_rdata = {32'hCAFEF00D, 32'h12345678, 32'hDEADBEEF, 32'hA5A5A5A5};
        test_reset();
        test_single_cycle();
        test_write_ignored();
        test_wait_states();
        test_back_to_back();
        test_nosel();
        test_multisel();
        test_timeout();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
